// File: rtl/banco_registradores_param_pkg.sv
// Shared constants and reset-image helper for the parametrised register bank.
// Optional build macro: ZERO_REG_EN (register 0 hard-wired to zero).
package banco_registradores_param_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 3;

   // Register i comes out of reset/clear holding its own index, truncated to data_w bits.
   function automatic logic [31:0] reset_image(input int unsigned idx, input int unsigned data_w);
      if (data_w >= 32)
         return idx;
      return idx % (32'd1 << data_w);
   endfunction

endpackage

// File: rtl/banco_registradores_param_porta_leitura.sv
// One registered read port: address mux, write forwarding, clear override, enabled output register.
// Optional build macro: ZERO_REG_EN (address 0 always reads as zero).
module banco_registradores_param_porta_leitura
   import banco_registradores_param_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   localparam int NREG  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_regs [NREG],
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_clr,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_next;

   // i_wr_en arrives already qualified (clear and protected addresses removed).
   always_comb begin
      w_next = i_regs[i_addr];
      if (i_clr)
         w_next = DATA_W'(reset_image(32'(i_addr), DATA_W));
      else if (i_wr_en && (i_wr_addr == i_addr))
         w_next = i_wr_data;
`ifdef ZERO_REG_EN
      if (i_addr == '0)
         w_next = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_data <= '0;
      else if (i_rd_en)
         r_data <= w_next;
   end

   assign o_data = r_data;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank: 2**ADDR_W x DATA_W, two registered read ports, one write port.
// Optional build macro: ZERO_REG_EN (register 0 reads zero, writes to it ignored).
module banco_registradores_param
   import banco_registradores_param_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   localparam int NREG  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addWr,
   input  logic [DATA_W-1:0] dadoWr,
   input  logic              rdEn1,
   input  logic [ADDR_W-1:0] addR1,
   output logic [DATA_W-1:0] dadoR1,
   input  logic              rdEn2,
   input  logic [ADDR_W-1:0] addR2,
   output logic [DATA_W-1:0] dadoR2,
   input  logic              clr,
   output logic [NREG-1:0]   escritos
);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_escritos;
   logic              w_wr_en;

   // Clear beats write; with ZERO_REG_EN a write to address 0 never happens at all.
`ifdef ZERO_REG_EN
   assign w_wr_en = wrEn && !clr && (addWr != '0);
`else
   assign w_wr_en = wrEn && !clr;
`endif

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         localparam logic [DATA_W-1:0] IMG = DATA_W'(reset_image(gi, DATA_W));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_regs[gi]     <= IMG;
               r_escritos[gi] <= 1'b0;
            end else if (clr) begin
               r_regs[gi]     <= IMG;
               r_escritos[gi] <= 1'b0;
            end else if (w_wr_en && (addWr == ADDR_W'(gi))) begin
               r_regs[gi]     <= dadoWr;
               r_escritos[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   banco_registradores_param_porta_leitura #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_porta1 (
      .clk       (clk),
      .rst       (rst),
      .i_rd_en   (rdEn1),
      .i_addr    (addR1),
      .i_regs    (r_regs),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (addWr),
      .i_wr_data (dadoWr),
      .i_clr     (clr),
      .o_data    (dadoR1)
   );

   banco_registradores_param_porta_leitura #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_porta2 (
      .clk       (clk),
      .rst       (rst),
      .i_rd_en   (rdEn2),
      .i_addr    (addR2),
      .i_regs    (r_regs),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (addWr),
      .i_wr_data (dadoWr),
      .i_clr     (clr),
      .o_data    (dadoR2)
   );

   assign escritos = r_escritos;

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
Parametrised successor of the 8x8 register bank used by the datapath: 2^ADDR_W registers of DATA_W bits, two registered read ports, one write port. Adds per-port read enables, write-to-read forwarding, a one-cycle synchronous bulk clear, and a per-register "written" bitmap. Sits between the decode stage (addresses) and the ALU (operands), with writeback driving the write port.

Parameters:
DATA_W, 8, register width in bits (>=4)
ADDR_W, 3, address width; depth NREG = 2**ADDR_W (1..6)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
wrEn  in  1  write enable
addWr  in  ADDR_W  write address
dadoWr  in  DATA_W  write data
rdEn1  in  1  read enable, port 1
addR1  in  ADDR_W  read address, port 1
dadoR1  out  DATA_W  registered read data, port 1
rdEn2  in  1  read enable, port 2
addR2  in  ADDR_W  read address, port 2
dadoR2  out  DATA_W  registered read data, port 2
clr  in  1  synchronous bulk clear to reset image
escritos  out  NREG  bit i = register i written since last reset/clear

Behaviour:
- Reset (rst=0, async, immediate): register i <= i mod 2**DATA_W; dadoR1, dadoR2 <= 0; escritos <= 0. Held while rst=0; reset mid-write discards the write.
- Read latency 1 cycle: if rdEnN=1 at edge k, dadoRN holds data from edge k until next enabled read; rdEnN=0 holds previous dadoRN.
- Write: if wrEn=1 and clr=0 at edge, reg[addWr] <= dadoWr; escritos[addWr] <= 1.
- Forwarding: same edge, rdEnN=1, wrEn=1, clr=0, addRN==addWr -> dadoRN <= dadoWr (new data, not old).
- Both ports may read the same address in the same cycle; both get identical data.
- clr=1 at edge: all registers <= reset image, escritos <= 0; clr has priority over wrEn (write dropped). An enabled read in the same cycle returns the reset image value (i mod 2**DATA_W), not old contents, not dadoWr.
- Addresses are full-range; no out-of-range case. Reset image truncation: with DATA_W small, high index bits dropped.
- No X propagation: dadoRN defined from reset onward.

Optional Feature:
Macro ZERO_REG_EN.
- Defined: register 0 reads as 0 always (reset image for index 0 is 0 already); writes to address 0 ignored, escritos[0] stays 0, forwarding to address 0 suppressed (read returns 0).
- Undefined: register 0 is an ordinary register, writable and forwardable.

Decomposition:
- Shared package: default DATA_W/ADDR_W constants, function producing reset image value for index i at width DATA_W.
- One natural sub-module: porta_leitura (one per read port) — address mux, forwarding compare, clear override, output register with enable; instantiated twice.

Test Plan:
- Reset then rdEn1=1 addR1=5, rdEn2=1 addR2=7 -> next cycle dadoR1=8'h05, dadoR2=8'h07, escritos=8'h00.
- wrEn=1 addWr=3 dadoWr=8'hA5 with rdEn1=1 addR1=3 same cycle -> dadoR1=8'hA5 next cycle (forwarded); escritos=8'h08.
- Write 8'h3C to reg 6, then rdEn2=0 for 3 cycles while wrEn writes 8'hFF to reg 6 -> dadoR2 unchanged; then rdEn2=1 addR2=6 -> 8'hFF.
- clr=1 with wrEn=1 addWr=2 dadoWr=8'h99 and rdEn1=1 addR1=2 -> dadoR1=8'h02, reg 2 stays 8'h02, escritos=0.
- Assert rst=0 asynchronously mid-cycle after writing 8'h11 to reg 4 -> dadoR1/dadoR2=0 immediately; after release read reg 4 -> 8'h04.
- ZERO_REG_EN defined: write 8'h77 to addr 0 with rdEn1=1 addR1=0 -> dadoR1=0, escritos[0]=0; undefined -> dadoR1=8'h77, escritos[0]=1. Also DATA_W=4, ADDR_W=5: read reg 20 after reset -> 4'h4.
